// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction opcode/funct fields, ALU function codes and datapath mux selects.
package mcpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_ADDU = 4'd11;
  localparam logic [3:0] ALU_SUBU = 4'd12;

  // datapath mux selects
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic [1:0] M2R_ALUOUT   = 2'd0;
  localparam logic [1:0] M2R_MDR      = 2'd1;
  localparam logic [1:0] M2R_PC       = 2'd2;
  localparam logic [1:0] RDST_RT      = 2'd0;
  localparam logic [1:0] RDST_RD      = 2'd1;
  localparam logic [1:0] RDST_RA      = 2'd2;
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_RS      = 2'd1;
  localparam logic [1:0] SRCA_SHAMT   = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

endpackage

// File: rtl/multi_cycle_controller_alu_op_decoder.sv
// Maps {opcode, funct} to the ALU function used in EX and flags encodings
// the controller does not support.
module alu_op_decoder
  import mcpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  // pure lookup; jumps and memory ops use ADD so the value is defined everywhere
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_JR, FN_JALR:  alu_op = ALU_ADD;
          FN_ADD:          alu_op = ALU_ADD;
          FN_ADDU:         alu_op = ALU_ADDU;
          FN_SUB:          alu_op = ALU_SUB;
          FN_SUBU:         alu_op = ALU_SUBU;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          default:         legal  = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_ADDI, OP_LUI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_ADDIU:       alu_op = ALU_ADDU;
      OP_SLTI:        alu_op = ALU_SLT;
      OP_SLTIU:       alu_op = ALU_SLTU;
      OP_ANDI:        alu_op = ALU_AND;
      OP_ORI:         alu_op = ALU_OR;
      OP_XORI:        alu_op = ALU_XOR;
      default:        legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control unit: owns the instruction register and sequences
// IF/ID/EX/MEM/WB, driving every datapath control combinationally from the
// current state and IR.
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | read memory at PC, load IR, PC <= PC+4
// ID    | branch target to ALUOut; jumps, jr/jalr and illegal words finish here
// EX    | ALU operation, address calc, or branch compare (branches finish)
// MEM   | lw read / sw write at ALUOut (sw finishes)
// WB    | register file write for lw, R-type and I-type ALU
module multi_cycle_controller
  import mcpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Mem_data,
  output logic [31:0] Instruction,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNe,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic        ExtOp,
  output logic        LuiOp,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        Illegal,
  output logic [2:0]  State
);

  state_e      state_q;
  logic [31:0] ir_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] dec_alu_op;
  logic       dec_legal;

  logic is_rtype, is_jr, is_jalr, is_j, is_jal, is_branch;
  logic is_lw, is_sw, is_ialu, is_ialu_sext, is_lui, is_shift;
  logic id_done;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  alu_op_decoder u_alu_op_decoder (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  assign is_rtype     = (opcode == OP_RTYPE);
  assign is_jr        = is_rtype && (funct == FN_JR);
  assign is_jalr      = is_rtype && (funct == FN_JALR);
  assign is_shift     = is_rtype && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
  assign is_j         = (opcode == OP_J);
  assign is_jal       = (opcode == OP_JAL);
  assign is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_lw        = (opcode == OP_LW);
  assign is_sw        = (opcode == OP_SW);
  assign is_ialu      = (opcode >= OP_ADDI) && (opcode <= OP_LUI);
  assign is_ialu_sext = (opcode >= OP_ADDI) && (opcode <= OP_SLTIU);
  assign is_lui       = (opcode == OP_LUI);
  // illegal words retire in ID alongside the jumps so nothing past decode fires
  assign id_done      = is_j || is_jal || is_jr || is_jalr || !dec_legal;

  // state register and IR; reset aborts whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IF;
      ir_q    <= '0;
    end else begin
      case (state_q)
        ST_IF: begin
          ir_q    <= Mem_data;
          state_q <= ST_ID;
        end
        ST_ID:   state_q <= id_done ? ST_IF : ST_EX;
        ST_EX: begin
          if (is_lw || is_sw)  state_q <= ST_MEM;
          else if (is_branch)  state_q <= ST_IF;
          else                 state_q <= ST_WB;
        end
        ST_MEM:  state_q <= is_lw ? ST_WB : ST_IF;
        ST_WB:   state_q <= ST_IF;
        default: state_q <= ST_IF;
      endcase
    end
  end

  // datapath controls decoded from state and IR, all held at 0 while in reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = IORD_PC;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = M2R_ALUOUT;
    RegDst      = RDST_RT;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALU_ADD;
    PCSource    = PCSRC_ALU;
    Illegal     = 1'b0;
    case (state_q)
      ST_IF: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCWrite  = 1'b1;
      end
      ST_ID: begin
        ALUSrcB = SRCB_IMM_SH2;
        ExtOp   = 1'b1;
        if (!dec_legal) begin
          Illegal = 1'b1;
        end else if (is_j || is_jal) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = RDST_RA;
            MemtoReg = M2R_PC;
          end
        end else if (is_jr || is_jalr) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_RS;
          if (is_jalr) begin
            RegWrite = 1'b1;
            RegDst   = RDST_RD;
            MemtoReg = M2R_PC;
          end
        end
      end
      ST_EX: begin
        if (is_rtype) begin
          ALUSrcA = is_shift ? SRCA_SHAMT : SRCA_RS;
          ALUSrcB = SRCB_RT;
          ALUOp   = dec_alu_op;
        end else if (is_ialu) begin
          // lui relies on rs=$0 so rs + (imm<<16) is the result
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_IMM;
          ExtOp   = is_ialu_sext;
          LuiOp   = is_lui;
          ALUOp   = dec_alu_op;
        end else if (is_lw || is_sw) begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_IMM;
          ExtOp   = 1'b1;
        end else if (is_branch) begin
          ALUSrcA     = SRCA_RS;
          ALUSrcB     = SRCB_RT;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          BranchNe    = (opcode == OP_BNE);
        end
      end
      ST_MEM: begin
        IorD     = IORD_ALUOUT;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        if (is_lw)         MemtoReg = M2R_MDR;
        else if (is_rtype) RegDst   = RDST_RD;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = IORD_PC;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = M2R_ALUOUT;
      RegDst      = RDST_RT;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RT;
      ALUOp       = ALU_ADD;
      PCSource    = PCSRC_ALU;
      Illegal     = 1'b0;
    end
  end

  assign Instruction = ir_q;
  assign State       = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: the driver pushes the expected
// per-cycle control vector for each issued instruction; a negedge monitor pops
// and compares.
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Mem_data;
  logic [31:0] Instruction;
  logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  MemtoReg, RegDst;
  logic        RegWrite, ExtOp, LuiOp;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        Illegal;
  logic [2:0]  State;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .Mem_data(Mem_data), .Instruction(Instruction),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Illegal(Illegal), .State(State)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] ir;
    logic pcw, pcwc, bne, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic rw, ext, lui;
    logic [1:0] srca, srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic ill;
  } ctrl_t;

  typedef enum {C_J, C_JAL, C_JR, C_JALR, C_ILL, C_BR, C_LW, C_SW, C_RALU, C_IALU} cat_e;

  ctrl_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b1;
  logic [31:0] prev_ir;

  logic [5:0] op_tab [0:13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
  logic [5:0] fn_tab [0:14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

  function automatic cat_e classify(input logic [31:0] w);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h08) return C_JR;
      if (fn == 6'h09) return C_JALR;
      if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2a, 6'h2b}) return C_RALU;
      return C_ILL;
    end
    if (op == 6'h02) return C_J;
    if (op == 6'h03) return C_JAL;
    if (op == 6'h04 || op == 6'h05) return C_BR;
    if (op >= 6'h08 && op <= 6'h0f) return C_IALU;
    if (op == 6'h23) return C_LW;
    if (op == 6'h2b) return C_SW;
    return C_ILL;
  endfunction

  function automatic int latency(input logic [31:0] w);
    case (classify(w))
      C_BR:                 return 3;
      C_SW, C_RALU, C_IALU: return 4;
      C_LW:                 return 5;
      default:              return 2;
    endcase
  endfunction

  // ALU codes: ADD0 SUB1 AND2 OR3 XOR4 NOR5 SLT6 SLTU7 SLL8 SRL9 SRA10 ADDU11 SUBU12
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h00: return 4'd8;   6'h02: return 4'd9;   6'h03: return 4'd10;
      6'h21: return 4'd11;  6'h22: return 4'd1;   6'h23: return 4'd12;
      6'h24: return 4'd2;   6'h25: return 4'd3;   6'h26: return 4'd4;
      6'h27: return 4'd5;   6'h2a: return 4'd6;   6'h2b: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h09: return 4'd11;  6'h0a: return 4'd6;   6'h0b: return 4'd7;
      6'h0c: return 4'd2;   6'h0d: return 4'd3;   6'h0e: return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // expected outputs during cycle k (0 = IF) of instruction w
  function automatic ctrl_t model(input logic [31:0] w, input int k, input logic [31:0] prev);
    ctrl_t c = '0;
    cat_e cat = classify(w);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    int st;
    if (k < 3)       st = k;
    else if (k == 3) st = (cat == C_LW || cat == C_SW) ? 3 : 4;
    else             st = 4;
    c.st = 3'(st);
    c.ir = (k == 0) ? prev : w;
    case (st)
      0: begin c.mrd = 1; c.irw = 1; c.srcb = 2'd1; c.pcw = 1; end
      1: begin
        c.srcb = 2'd3; c.ext = 1;
        case (cat)
          C_J:    begin c.pcw = 1; c.pcsrc = 2'd2; end
          C_JAL:  begin c.pcw = 1; c.pcsrc = 2'd2; c.rw = 1; c.rdst = 2'd2; c.m2r = 2'd2; end
          C_JR:   begin c.pcw = 1; c.pcsrc = 2'd3; end
          C_JALR: begin c.pcw = 1; c.pcsrc = 2'd3; c.rw = 1; c.rdst = 2'd1; c.m2r = 2'd2; end
          C_ILL:  c.ill = 1;
          default: ;
        endcase
      end
      2: begin
        case (cat)
          C_RALU: begin
            c.srca = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'd2 : 2'd1;
            c.aluop = r_alu(fn);
          end
          C_IALU: begin
            c.srca = 2'd1; c.srcb = 2'd2; c.ext = (op <= 6'h0b);
            c.lui = (op == 6'h0f); c.aluop = i_alu(op);
          end
          C_LW, C_SW: begin c.srca = 2'd1; c.srcb = 2'd2; c.ext = 1; end
          C_BR: begin
            c.srca = 2'd1; c.aluop = 4'd1; c.pcwc = 1; c.pcsrc = 2'd1;
            c.bne = (op == 6'h05);
          end
          default: ;
        endcase
      end
      3: begin c.iord = 1; c.mrd = (cat == C_LW); c.mwr = (cat == C_SW); end
      default: begin
        c.rw = 1;
        if (cat == C_LW)   c.m2r = 2'd1;
        if (cat == C_RALU) c.rdst = 2'd1;
      end
    endcase
    return c;
  endfunction

  function automatic logic [31:0] rand_word();
    int r = $urandom_range(0, 11);
    logic [31:0] w = $urandom;
    if (r == 0) return w;
    if (r == 1) return 32'h0;
    if (r <= 3) begin
      w[31:26] = 6'h00;
      if (r == 3) w[5:0] = fn_tab[$urandom_range(0, 14)];
      return w;
    end
    w[31:26] = op_tab[$urandom_range(0, 13)];
    return w;
  endfunction

  // issue one instruction; ncyc < latency stops early (used for the abort case)
  task automatic run_instr(input logic [31:0] w, input int ncyc);
    int n = (ncyc > 0) ? ncyc : latency(w);
    for (int k = 0; k < n; k++) exp_q.push_back(model(w, k, prev_ir));
    Mem_data = w;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      Mem_data = $urandom;
    end
    prev_ir = w;
  endtask

  // monitor: every negedge is one DUT output presentation
  always @(negedge clk) begin
    ctrl_t act, e;
    if (mon_en) begin
      act = '{State, Instruction, PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
              IRWrite, MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp,
              PCSource, Illegal};
      if (!reset) begin
        act.st = '0;
        act.ir = '0;
        n_vec++;
        if (act !== ctrl_t'('0)) begin
          n_err++;
          $display("FAIL reset_controls t=%0t got=%h required=0", $time, act);
        end
      end else if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL no_expectation t=%0t got=%h", $time, act);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t got=%h required=%h", $time, act, e);
        end
      end
      n_vec++;
      if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
        n_err++;
        $display("FAIL exclusive_enables t=%0t got mrd=%b mwr=%b pcw=%b pcwc=%b required no pair",
                 $time, MemRead, MemWrite, PCWrite, PCWriteCond);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  logic [31:0] directed [0:9] = '{32'h20040005, 32'h8fa40000, 32'hafbf0004, 32'h1100fffe,
                                  32'h1500ffff, 32'h0c000004, 32'h03e00008, 32'hfc000000,
                                  32'h00000000, 32'h3c011234};

  initial begin
    reset    = 1'b0;
    Mem_data = $urandom;
    prev_ir  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (directed[i]) run_instr(directed[i], 0);
    run_instr(32'h0020f809, 0);   // jalr
    run_instr(32'h00851002, 0);   // srl

    // reset while lw sits in MEM: nothing after it may write
    run_instr(32'h8fa40000, 3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    prev_ir = '0;

    for (int i = 0; i < 200; i++) run_instr(rand_word(), 0);

    mon_en = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
